product_accumulator: RTL and testbench

- Sequential stage directly downstream of the 4-bit combinational multiplier.
- Accepts a stream of 8-bit products over a valid/ready handshake and sums each group of N consecutive products, giving a dot product of N operand pairs.
- Presents each group result on a registered valid/ready output port and flags wrap-around of the accumulator width.

---
 rtl/mult_pkg.sv | 22 ++
 rtl/product_accumulator.sv | 116 +++++++++++
 tb/tb_product_accumulator.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the 4-bit multiplier stage and its downstream
// product accumulator: operand/product widths, accumulator FSM states and
// the group counter width helper.
package mult_pkg;

  // Operand and product widths of the combinational multiplier.
  localparam int OPERAND_W = 4;
  localparam int PROD_W    = 8;

  // Accumulator FSM: summing a group, or presenting a finished group result.
  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } acc_state_e;

  // Width of a counter that indexes 0..n-1; a single group member still
  // needs one bit so the counter never collapses to zero width.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/product_accumulator.sv
// Sums groups of N consecutive unsigned products received over a
// valid/ready handshake and presents each group sum on a registered
// valid/ready output, with a sticky flag for accumulator wrap-around.
module product_accumulator
  import mult_pkg::*;
#(
  parameter int PW = PROD_W,
  parameter int N  = 4,
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] prod,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] sum,
  output logic          overflow
);

  localparam int            CW       = cnt_width(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  acc_state_e    state_q, state_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic [AW-1:0] sum_q, sum_d;
  logic          out_valid_q, out_valid_d;
  logic          overflow_q, overflow_d;

  // One extra bit on the adder exposes the carry out of the accumulator.
  logic [AW:0]   add_full;

  assign add_full = {1'b0, acc_q} + (AW + 1)'(prod);

  // Input is only taken while summing, and never in a cycle being aborted.
  assign in_ready  = (state_q == ACC) & ~clear;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign overflow  = overflow_q;

  // Next-state and datapath: clear aborts, otherwise accumulate or hand off.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    sum_d       = sum_q;
    out_valid_d = out_valid_q;
    overflow_d  = overflow_q;

    if (clear) begin
      // sum/overflow are left as-is; they are meaningless once out_valid drops.
      acc_d       = '0;
      cnt_d       = '0;
      ovf_d       = 1'b0;
      out_valid_d = 1'b0;
      state_d     = ACC;
    end else begin
      unique case (state_q)
        ACC: begin
          // in_ready is high here, so in_valid alone means a transfer.
          if (in_valid) begin
            if (cnt_q == CNT_LAST) begin
              sum_d       = add_full[AW-1:0];
              overflow_d  = ovf_q | add_full[AW];
              out_valid_d = 1'b1;
              acc_d       = '0;
              cnt_d       = '0;
              ovf_d       = 1'b0;
              state_d     = HOLD;
            end else begin
              acc_d = add_full[AW-1:0];
              ovf_d = ovf_q | add_full[AW];
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        HOLD: begin
          // Result stays put until the consumer takes it; the next group
          // starts only on the following cycle.
          if (out_ready) begin
            out_valid_d = 1'b0;
            state_d     = ACC;
          end
        end
        default: state_d = ACC;
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACC;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      sum_q       <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      sum_q       <= sum_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: three instances (N=4/AW=12, N=4/AW=9,
// N=1/AW=12) share one stimulus stream; each has a queue-based reference
// model that sums whole groups and is compared every cycle.
module tb_product_accumulator;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clear_s = 1'b0;
  logic       in_valid_s = 1'b0;
  logic [7:0] prod_s = 8'd0;
  logic       out_ready_s = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int NN  = (gi == 2) ? 1 : 4;
    localparam int AWI = (gi == 1) ? 9 : 12;

    logic           in_ready_w;
    logic           out_valid_w;
    logic [AWI-1:0] sum_w;
    logic           ovf_w;

    product_accumulator #(.PW(8), .N(NN), .AW(AWI)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .clear     (clear_s),
      .in_valid  (in_valid_s),
      .in_ready  (in_ready_w),
      .prod      (prod_s),
      .out_valid (out_valid_w),
      .out_ready (out_ready_s),
      .sum       (sum_w),
      .overflow  (ovf_w)
    );

    // Reference model: products of the open group, held-result flag, last result.
    int          grp[$];
    bit          hold = 1'b0;
    int unsigned rsum = 0;
    bit          rovf = 1'b0;

    initial forever begin
      @(posedge clk);
      if (rst) begin
        grp.delete();
        hold = 1'b0;
        rsum = 0;
        rovf = 1'b0;
      end else if (clear_s) begin
        grp.delete();
        hold = 1'b0;
      end else if (hold) begin
        if (out_ready_s) hold = 1'b0;
      end else if (in_valid_s) begin
        grp.push_back(int'(prod_s));
        if (grp.size() == NN) begin
          int unsigned t;
          t = 0;
          foreach (grp[k]) t += grp[k];
          rsum = t % (32'd1 << AWI);
          rovf = (t >= (32'd1 << AWI));
          grp.delete();
          hold = 1'b1;
        end
      end
    end

    initial forever begin
      @(negedge clk);
      if (!rst) begin
        chk($sformatf("u%0d_in_ready", gi), 32'(in_ready_w), 32'(!hold && !clear_s));
        chk($sformatf("u%0d_out_valid", gi), 32'(out_valid_w), 32'(hold));
        chk($sformatf("u%0d_sum", gi), 32'(sum_w), rsum);
        chk($sformatf("u%0d_overflow", gi), 32'(ovf_w), 32'(rovf));
      end
    end
  end

  // Drive one cycle of inputs, returning 2 time units after the next edge.
  task automatic step(input logic v, input int p, input logic ordy, input logic clr);
    in_valid_s  = v;
    prod_s      = 8'(p);
    out_ready_s = ordy;
    clear_s     = clr;
    @(posedge clk);
    #2;
  endtask

  initial begin
    // Reset / idle
    rst = 1'b1;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    rst = 1'b0;
    step(0, 0, 1, 0);
    chk("idle_out_valid", 32'(g_dut[0].out_valid_w), 32'd0);
    chk("idle_in_ready", 32'(g_dut[0].in_ready_w), 32'd1);
    chk("idle_sum", 32'(g_dut[0].sum_w), 32'd0);
    chk("idle_overflow", 32'(g_dut[0].ovf_w), 32'd0);

    // Basic group
    step(1, 15, 1, 0);
    step(1, 30, 1, 0);
    step(1, 45, 1, 0);
    step(1, 60, 1, 0);
    chk("basic_out_valid", 32'(g_dut[0].out_valid_w), 32'd1);
    chk("basic_sum", 32'(g_dut[0].sum_w), 32'd150);
    chk("basic_overflow", 32'(g_dut[0].ovf_w), 32'd0);
    step(0, 0, 1, 0);
    chk("basic_in_ready_after", 32'(g_dut[0].in_ready_w), 32'd1);
    step(0, 0, 1, 0);

    // Backpressure and gaps
    step(1, 225, 0, 0);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(1, 1, 0, 0);
    step(0, 0, 0, 0);
    step(1, 225, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(1, 99, 0, 0);
      chk("bp_out_valid", 32'(g_dut[0].out_valid_w), 32'd1);
      chk("bp_sum", 32'(g_dut[0].sum_w), 32'd451);
      chk("bp_in_ready", 32'(g_dut[0].in_ready_w), 32'd0);
    end
    step(0, 0, 1, 0);
    chk("bp_released", 32'(g_dut[0].out_valid_w), 32'd0);
    step(0, 0, 1, 0);

    // Overflow on the AW=9 instance, then sticky flag cleared per group
    for (int i = 0; i < 4; i++) step(1, 225, 1, 0);
    chk("ovf_sum", 32'(g_dut[1].sum_w), 32'd388);
    chk("ovf_flag", 32'(g_dut[1].ovf_w), 32'd1);
    chk("ovf_wide_sum", 32'(g_dut[0].sum_w), 32'd900);
    step(0, 0, 1, 0);
    for (int i = 1; i <= 4; i++) step(1, i, 1, 0);
    chk("ovf_next_sum", 32'(g_dut[1].sum_w), 32'd10);
    chk("ovf_next_flag", 32'(g_dut[1].ovf_w), 32'd0);
    step(0, 0, 1, 0);

    // Clear mid-group, with in_valid in the same cycle
    step(1, 100, 1, 0);
    step(1, 100, 1, 0);
    step(1, 50, 1, 1);
    for (int i = 7; i <= 10; i++) step(1, i, 1, 0);
    chk("clr_sum", 32'(g_dut[0].sum_w), 32'd34);
    chk("clr_overflow", 32'(g_dut[0].ovf_w), 32'd0);
    step(0, 0, 1, 0);

    // Clear while holding a result
    for (int i = 0; i < 4; i++) step(1, 3, 0, 0);
    chk("clrhold_before", 32'(g_dut[0].out_valid_w), 32'd1);
    step(0, 0, 0, 1);
    chk("clrhold_after", 32'(g_dut[0].out_valid_w), 32'd0);

    // Reset mid-group, then a fresh group
    step(1, 5, 1, 0);
    step(1, 6, 1, 0);
    rst = 1'b1;
    step(0, 0, 1, 0);
    rst = 1'b0;
    chk("rst_out_valid", 32'(g_dut[0].out_valid_w), 32'd0);
    chk("rst_sum", 32'(g_dut[0].sum_w), 32'd0);
    for (int i = 1; i <= 4; i++) step(1, 2 * i, 1, 0);
    chk("rst_fresh_sum", 32'(g_dut[0].sum_w), 32'd20);
    step(0, 0, 1, 0);

    // Randomized traffic checked by the per-instance models
    for (int i = 0; i < 2000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      step($urandom_range(0, 3) != 0,
           int'($urandom_range(0, 15) * $urandom_range(0, 15)),
           $urandom_range(0, 2) != 0,
           $urandom_range(0, 59) == 0);
    end
    rst = 1'b0;
    step(0, 0, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
